// File: rtl/climate_pkg.sv
// Shared widths, result codes and scheduler state encoding for the climate engine scheduler.
package climate_pkg;
  localparam int TEMP_W = 8;
  localparam int PRES_W = 11;
  localparam int COND_W = 3;
  localparam logic [COND_W-1:0] COND_TIMEOUT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_state_e;
endpackage

// File: rtl/climate_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr, wrapping at N_REQ.
module climate_rr_arbiter
  import climate_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             grant_valid
);
  localparam int CW = IDW + 1;

  logic [CW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the others.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (req[cand[IDW-1:0]]) begin
        grant_idx   = cand[IDW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign grant[gi] = grant_valid && (grant_idx == IDW'(gi));
  end
endmodule

// File: rtl/climate_engine_scheduler.sv
// Shares one climate prediction engine between N_REQ requesters with round-robin arbitration.
// Optional engine watchdog is built in when CLIMATE_TIMEOUT_EN is defined.
module climate_engine_scheduler
  import climate_pkg::*;
#(
  parameter int  N_REQ       = 4,
  parameter int  TIMEOUT_CYC = 64,
  localparam int IDW         = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*TEMP_W-1:0]   req_temperature,
  input  logic [N_REQ*PRES_W-1:0]   req_pressure,
  output logic                      eng_start,
  output logic [TEMP_W-1:0]         eng_temperature,
  output logic [PRES_W-1:0]         eng_pressure,
  input  logic                      eng_done,
  input  logic [COND_W-1:0]         eng_condition,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [COND_W-1:0]         rsp_condition,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy
);
  sched_state_e      state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [PRES_W-1:0] pres_q, pres_d;
  logic [COND_W-1:0] cond_q, cond_d;
  logic              eng_start_q, eng_start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_valid;
  logic              timed_out;

  climate_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

`ifdef CLIMATE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT && !eng_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timed_out = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
  // The watchdog limit has no effect when the watchdog is not built in.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    temp_d      = temp_q;
    pres_d      = pres_q;
    cond_d      = cond_q;
    eng_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          temp_d      = req_temperature[TEMP_W*grant_idx +: TEMP_W];
          pres_d      = req_pressure[PRES_W*grant_idx +: PRES_W];
          id_d        = grant_idx;
          ptr_d       = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
          eng_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A real result wins over a watchdog expiry landing in the same cycle.
        if (eng_done) begin
          cond_d      = eng_condition;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timed_out) begin
          cond_d      = COND_TIMEOUT;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      temp_q      <= '0;
      pres_q      <= '0;
      cond_q      <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CLIMATE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      temp_q      <= temp_d;
      pres_q      <= pres_d;
      cond_q      <= cond_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef CLIMATE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Gated by rst_n so a pending request cannot show a grant while reset is held.
  assign req_ready       = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign eng_start       = eng_start_q;
  assign eng_temperature = temp_q;
  assign eng_pressure    = pres_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_condition   = cond_q;
  assign rsp_id          = id_q;
  assign busy            = busy_q;
endmodule
